// File: rtl/morse_playback_sequencer.sv
// morse_playback_sequencer
//
// Plays a stored message of up to MAX_CHARS Morse characters as timed tone
// on/off intervals. Characters are fetched one at a time by index; each
// character's symbols (dot = 1 unit, dash = 3 units) are played with 1-unit
// gaps between symbols and 3-unit gaps between characters. A zero-length
// character is a word space (4 units of silence).
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   start_i       one-cycle pulse; begins playback when idle
//   abort_i       level; returns to idle from any state
//   speed_sel_i   unit = UNIT_CYCLES >> speed_sel (3 behaves as 2); sampled at start
//   char_count_i  characters to play, 0..8 (larger values clamp); sampled at start
//   char_idx_o    index of the character being fetched/played (registered)
//   code_len_i    symbol count for char_idx_o (0 = word space, 6/7 clamp to 5)
//   code_bits_i   symbols MSB-first within code_len_i; 1 = dash, 0 = dot
//   beep_en_o     tone enable (registered)
//   busy_o        playback in progress (registered)
//   done_o        one-cycle pulse on normal completion (registered)
module morse_playback_sequencer #(
  parameter int unsigned UNIT_CYCLES = 10_000_000,
  parameter int unsigned MAX_CHARS   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [1:0] speed_sel_i,
  input  logic [3:0] char_count_i,
  output logic [2:0] char_idx_o,
  input  logic [2:0] code_len_i,
  input  logic [4:0] code_bits_i,
  output logic       beep_en_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned UnitW    = $clog2(UNIT_CYCLES + 1);
  localparam logic [3:0]  MaxChars = 4'(MAX_CHARS);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StTone,
    StSgap,
    StCgap,
    StWgap,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [UnitW-1:0] unit_cnt_q, unit_cnt_d;
  logic [1:0]       units_q, units_d;     // whole units left after the current one
  logic [3:0]       char_cnt_q, char_cnt_d;
  logic [3:0]       count_q, count_d;
  logic [1:0]       shift_q, shift_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       bits_q, bits_d;
  logic [2:0]       sym_q, sym_d;
  logic             beep_q, busy_q, done_q;

  logic [UnitW-1:0] unit_reload;
  logic [3:0]       count_clamped;
  logic [1:0]       shift_clamped;
  logic [2:0]       len_clamped;
  logic             timed;
  logic             period_end;
  logic             more_syms;
  logic             last_char;
  logic             enter;
  logic [2:0]       tone_pos;
  logic [4:0]       tone_shift;

  assign unit_reload   = UnitW'((UNIT_CYCLES >> shift_q) - 1);
  assign count_clamped = (char_count_i > MaxChars) ? MaxChars : char_count_i;
  assign shift_clamped = (speed_sel_i == 2'b11) ? 2'b10 : speed_sel_i;
  assign len_clamped   = (code_len_i > 3'd5) ? 3'd5 : code_len_i;

  assign timed      = state_q inside {StTone, StSgap, StCgap, StWgap};
  assign period_end = (unit_cnt_q == '0) && (units_q == 2'd0);
  assign more_syms  = ({1'b0, sym_q} + 4'd1) < {1'b0, len_q};
  assign last_char  = (char_cnt_q + 4'd1) == count_q;

  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    char_cnt_d = char_cnt_q;
    count_d    = count_q;
    shift_d    = shift_q;
    len_d      = len_q;
    bits_d     = bits_q;
    sym_d      = sym_q;
    enter      = 1'b0;
    tone_pos   = 3'd0;
    tone_shift = 5'd0;

    // Two-level countdown: unit_cnt ticks cycles within a unit, units counts
    // the remaining whole units, so a state lasts exactly N x unit cycles.
    if (timed && !period_end) begin
      if (unit_cnt_q == '0) begin
        unit_cnt_d = unit_reload;
        units_d    = units_q - 2'd1;
      end else begin
        unit_cnt_d = unit_cnt_q - UnitW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        // busy_q stays high for the done cycle; a start there is still "while busy"
        if (start_i && !busy_q) begin
          count_d    = count_clamped;
          shift_d    = shift_clamped;
          char_cnt_d = 4'd0;
          state_d    = (count_clamped == 4'd0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        len_d   = len_clamped;
        bits_d  = code_bits_i;
        sym_d   = 3'd0;
        enter   = 1'b1;
        state_d = (len_clamped == 3'd0) ? StWgap : StTone;
      end
      StTone: begin
        if (period_end) begin
          enter = 1'b1;
          if (more_syms) begin
            state_d = StSgap;
          end else if (last_char) begin
            state_d = StDone;
          end else begin
            state_d = StCgap;
          end
        end
      end
      StSgap: begin
        if (period_end) begin
          enter   = 1'b1;
          sym_d   = sym_q + 3'd1;
          state_d = StTone;
        end
      end
      StCgap: begin
        if (period_end) begin
          char_cnt_d = char_cnt_q + 4'd1;
          state_d    = StFetch;
        end
      end
      StWgap: begin
        if (period_end) begin
          if (last_char) begin
            state_d = StDone;
          end else begin
            char_cnt_d = char_cnt_q + 4'd1;
            state_d    = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Symbol i of the upcoming tone lives at bit (len - 1 - i).
    tone_pos   = len_d - sym_d - 3'd1;
    tone_shift = bits_d >> tone_pos;

    if (enter) begin
      unit_cnt_d = unit_reload;
      unique case (state_d)
        StTone:  units_d = tone_shift[0] ? 2'd2 : 2'd0;
        StCgap:  units_d = 2'd2;
        StWgap:  units_d = 2'd3;
        default: units_d = 2'd0;
      endcase
    end

    if (abort_i) begin
      state_d = StIdle;
    end
  end

  // beep/done are registered from the current state, so they trail the state by
  // one cycle; busy covers both the state span and that trailing done cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      unit_cnt_q <= '0;
      units_q    <= 2'd0;
      char_cnt_q <= 4'd0;
      count_q    <= 4'd0;
      shift_q    <= 2'd0;
      len_q      <= 3'd0;
      bits_q     <= 5'd0;
      sym_q      <= 3'd0;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      char_cnt_q <= char_cnt_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      bits_q     <= bits_d;
      sym_q      <= sym_d;
      beep_q     <= !abort_i && (state_q == StTone);
      done_q     <= !abort_i && (state_q == StDone);
      busy_q     <= !abort_i && ((state_d != StIdle) || (state_q == StDone));
    end
  end

  assign char_idx_o = char_cnt_q[2:0];
  assign beep_en_o  = beep_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_morse_playback_sequencer.sv
module tb_morse_playback_sequencer;

  localparam int Unit      = 8;
  localparam int EvDone    = 100;
  localparam int EvBusyLow = 200;
  localparam int EvAbort   = 300;
  localparam int EvStray   = 400;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       abort_i;
  logic [1:0] speed_sel_i;
  logic [3:0] char_count_i;
  logic [2:0] char_idx_o;
  logic [2:0] code_len_i;
  logic [4:0] code_bits_i;
  logic       beep_en_o;
  logic       busy_o;
  logic       done_o;

  logic [2:0] msg_len  [8];
  logic [4:0] msg_bits [8];

  assign code_len_i  = msg_len[char_idx_o];
  assign code_bits_i = msg_bits[char_idx_o];

  morse_playback_sequencer #(
    .UNIT_CYCLES(Unit),
    .MAX_CHARS  (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .speed_sel_i (speed_sel_i),
    .char_count_i(char_count_i),
    .char_idx_o  (char_idx_o),
    .code_len_i  (code_len_i),
    .code_bits_i (code_bits_i),
    .beep_en_o   (beep_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int val;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Scoreboard compare: one observed event against the oldest expected one.
  task automatic emit(input int val, input int len);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: unexpected event val=%0d len=%0d (nothing expected)", val, len);
    end else begin
      e = exp_q.pop_front();
      if (e.val != val || e.len != len) begin
        n_fail++;
        $display("FAIL scoreboard: got val=%0d len=%0d, expected val=%0d len=%0d",
                 val, len, e.val, e.len);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compresses the sampled (beep, char_idx) stream into runs while busy
  // and reports run boundaries, completion, abort and any stray activity.
  bit active    = 1'b0;
  bit post_done = 1'b0;
  int run_val   = 0;
  int run_len   = 0;

  initial begin
    int v;
    forever begin
      @(negedge clk_i);
      v = int'(beep_en_o) * 8 + int'(char_idx_o);
      if (post_done) begin
        emit(EvBusyLow, int'(busy_o));
        post_done = 1'b0;
      end else if (!active) begin
        if (busy_o === 1'b1) begin
          active  = 1'b1;
          run_val = v;
          run_len = 1;
        end else if (done_o !== 1'b0 || beep_en_o !== 1'b0) begin
          emit(EvStray, 0);
        end
      end else if (busy_o !== 1'b1) begin
        emit(run_val, run_len);
        emit(EvAbort, 0);
        active = 1'b0;
      end else begin
        if (v != run_val) begin
          emit(run_val, run_len);
          run_val = v;
          run_len = 1;
        end else begin
          run_len++;
        end
        if (done_o === 1'b1) begin
          emit(run_val, run_len);
          emit(EvDone, 0);
          active    = 1'b0;
          post_done = 1'b1;
        end
      end
    end
  end

  // Reference model: lay out the playback cycle by cycle from the Morse timing
  // rules, then derive the sampled view (tone shows one cycle after its state
  // cycle, the index shows immediately) and compress it into expected runs.
  task automatic build_expected(input int n, input int unit, input int cut, input bit do_push,
                                output int len_out, output int beep_at_cut);
    int bs[$];
    int is[$];
    int obs[$];
    int cl, dur, big_l, m, v, rl;
    for (int c = 0; c < n; c++) begin
      cl = (msg_len[c] > 5) ? 5 : int'(msg_len[c]);
      bs.push_back(0); is.push_back(c);
      if (cl == 0) begin
        for (int t = 0; t < 4 * unit; t++) begin bs.push_back(0); is.push_back(c); end
      end else begin
        for (int s = 0; s < cl; s++) begin
          dur = msg_bits[c][cl-1-s] ? 3 * unit : unit;
          for (int t = 0; t < dur; t++) begin bs.push_back(1); is.push_back(c); end
          if (s < cl - 1)
            for (int t = 0; t < unit; t++) begin bs.push_back(0); is.push_back(c); end
        end
        if (c < n - 1)
          for (int t = 0; t < 3 * unit; t++) begin bs.push_back(0); is.push_back(c); end
      end
    end
    bs.push_back(0); is.push_back((n == 0) ? 0 : n - 1);
    big_l = bs.size();
    for (int j = 0; j <= big_l; j++)
      obs.push_back(((j == 0) ? 0 : bs[j-1]) * 8 + ((j < big_l) ? is[j] : is[big_l-1]));
    len_out     = big_l;
    beep_at_cut = (cut >= 0 && cut <= big_l) ? obs[cut] / 8 : 0;
    if (do_push) begin
      m  = (cut > 0) ? cut : big_l + 1;
      v  = obs[0];
      rl = 0;
      for (int j = 0; j < m; j++) begin
        if (obs[j] == v) rl++;
        else begin
          exp_q.push_back('{val: v, len: rl});
          v  = obs[j];
          rl = 1;
        end
      end
      exp_q.push_back('{val: v, len: rl});
      if (cut > 0) begin
        exp_q.push_back('{val: EvAbort, len: 0});
      end else begin
        exp_q.push_back('{val: EvDone, len: 0});
        exp_q.push_back('{val: EvBusyLow, len: 0});
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk_i);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d events still expected after %0d cycles", exp_q.size(), t);
      exp_q.delete();
    end
  endtask

  // mode 0: play to completion, 1: abort at sample cut, 2: async reset at sample cut
  task automatic run_msg(input int cnt, input int spd, input int mode_in, input int cut_req,
                         input bit noise);
    int n, unit, big_l, cut, bb, d, mode;
    n    = (cnt > 8) ? 8 : cnt;
    unit = Unit >> ((spd > 2) ? 2 : spd);
    mode = mode_in;
    build_expected(n, unit, -1, 1'b0, big_l, bb);
    if (big_l < 2) mode = 0;
    cut = -1;
    if (mode != 0) cut = (cut_req > 0 && cut_req < big_l) ? cut_req : $urandom_range(1, big_l - 1);
    build_expected(n, unit, cut, 1'b1, big_l, bb);
    @(negedge clk_i);
    char_count_i = 4'(cnt);
    speed_sel_i  = 2'(spd);
    start_i      = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    if (mode == 1) begin
      repeat (cut - 1) @(posedge clk_i);
      @(negedge clk_i);
      abort_i = 1'b1;
      @(posedge clk_i);
      #1 abort_i = 1'b0;
      check("abort_busy", int'(busy_o), 0);
      check("abort_beep", int'(beep_en_o), 0);
    end else if (mode == 2) begin
      repeat (cut) @(posedge clk_i);
      #1 check("beep_before_reset", int'(beep_en_o), bb);
      #1 rst_ni = 1'b0;
      #1;
      check("async_reset_beep", int'(beep_en_o), 0);
      check("async_reset_busy", int'(busy_o), 0);
      check("async_reset_idx", int'(char_idx_o), 0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
    end else if (noise && big_l >= 3) begin
      d = $urandom_range(1, big_l - 1);
      repeat (d - 1) @(posedge clk_i);
      @(negedge clk_i);
      start_i      = 1'b1;
      speed_sel_i  = 2'($urandom);
      char_count_i = 4'($urandom);
      @(posedge clk_i);
      #1 start_i = 1'b0;
    end
    drain();
    repeat (3) @(negedge clk_i);
  endtask

  task automatic set_msg(input int i, input int len, input int bits);
    msg_len[i]  = 3'(len);
    msg_bits[i] = 5'(bits);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    speed_sel_i  = 2'd0;
    char_count_i = 4'd0;
    for (int i = 0; i < 8; i++) set_msg(i, 0, 0);
    repeat (3) @(negedge clk_i);
    check("reset_beep", int'(beep_en_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_idx", int'(char_idx_o), 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Speed 1 gives a 4-cycle unit.
    set_msg(0, 1, 5'b00000);                       // E
    run_msg(1, 1, 0, 0, 1'b0);
    set_msg(0, 2, 5'b00001);                       // A
    run_msg(1, 1, 0, 0, 1'b0);
    set_msg(0, 1, 5'b00000); set_msg(1, 1, 5'b00001);  // E T
    run_msg(2, 1, 0, 0, 1'b0);
    set_msg(0, 1, 5'b00000); set_msg(1, 0, 5'b00000); set_msg(2, 1, 5'b00000);  // E _ E
    run_msg(3, 1, 0, 0, 1'b0);
    run_msg(0, 1, 0, 0, 1'b0);                     // empty message
    set_msg(0, 1, 5'b00000);
    run_msg(1, 0, 0, 0, 1'b0);
    run_msg(1, 2, 0, 0, 1'b0);
    run_msg(1, 3, 0, 0, 1'b0);
    set_msg(0, 1, 5'b00001);                       // T: abort 6 cycles into the dash
    run_msg(1, 1, 1, 8, 1'b0);
    run_msg(1, 1, 2, 10, 1'b0);
    set_msg(0, 7, 5'b10110);                       // length 7 clamps to 5
    run_msg(1, 2, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) set_msg(i, $urandom_range(0, 7), $urandom);
    run_msg(12, 3, 0, 0, 1'b1);                    // count clamps to 8, start while busy

    // start coincident with abort is ignored
    @(negedge clk_i);
    char_count_i = 4'd1;
    start_i      = 1'b1;
    abort_i      = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    abort_i = 1'b0;
    check("start_with_abort_busy", int'(busy_o), 0);
    repeat (4) @(negedge clk_i);

    for (int r = 0; r < 30; r++) begin
      int cnt, spd, mode;
      for (int i = 0; i < 8; i++) set_msg(i, $urandom_range(0, 7), $urandom);
      cnt  = $urandom_range(0, 10);
      spd  = $urandom_range(0, 3);
      mode = $urandom_range(0, 5);
      if (mode > 2) mode = 0;
      run_msg(cnt, spd, mode, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_playback_sequencer.md
Name: morse_playback_sequencer

Overview:
- Plays a stored message of up to 8 Morse characters as timed tone on/off intervals.
- Sits between the character register and the buzzer driver. It fetches one character's Morse code at a time by index, then drives a tone-enable with dot/dash/gap timing.
- The timing base is a configurable unit length with a runtime speed select.

Parameters:
- UNIT_CYCLES, 10_000_000, clk cycles per Morse unit at speed_sel=0. 100 ms at 100 MHz. Must be ≥4.
- MAX_CHARS, 8, message capacity. char_idx width is 3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins playback. Ignored unless in IDLE.
- abort  in  1  level; returns to IDLE from any state.
- speed_sel  in  2  unit = UNIT_CYCLES >> speed_sel. 00=1x, 01=2x, 10=4x faster; 11 behaves as 10. Sampled at start.
- char_count  in  4  number of characters to play, 0..8. Values >8 clamp to 8. Sampled at start.
- char_idx  out  3  index of the character being fetched or played. Registered.
- code_len  in  3  symbol count of the character at char_idx. 0 = word space; 6/7 clamp to 5.
- code_bits  in  5  symbols, MSB-first within code_len: symbol i = bit (code_len-1-i). 1 = dash, 0 = dot.
- beep_en  out  1  tone on. Registered.
- busy  out  1  high in every state except IDLE. Registered.
- done  out  1  one-cycle pulse on normal completion. Not asserted on abort.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, beep_en=0, busy=0, done=0, char_idx=0, all counters 0. Takes effect immediately, including mid-tone.
- Unit counter: reloads to unit-1 on every state entry. Each state lasts N×unit cycles exactly, where N is given per state below.
- States:
  - IDLE: wait for start.
    - start=1 and clamped char_count=0 → DONE.
    - start=1 otherwise → FETCH with char_idx=0, and speed/count latched.
  - FETCH (1 cycle): code_len/code_bits sampled for the current char_idx. They must be stable combinationally from char_idx.
    - len=0 → WGAP.
    - len≠0 → TONE at symbol 0.
  - TONE: beep_en=1. Lasts 1 unit for a dot, 3 units for a dash.
    - If more symbols remain → SGAP.
    - Else if last character → DONE.
    - Else → CGAP.
  - SGAP: beep_en=0 for 1 unit → TONE with the next symbol.
  - CGAP: beep_en=0 for 3 units; char_idx increments → FETCH.
  - WGAP: beep_en=0 for 4 units.
    - If last character → DONE.
    - Else char_idx increments → FETCH.
  - DONE (1 cycle): done=1, busy=1 → IDLE. char_idx is left as is.
- Latency: start sampled on edge k → busy=1 after edge k. beep_en for the first symbol rises after edge k+2, since FETCH occupies one cycle.
- No trailing gap after the final character.
- abort: takes priority over all transitions. Next edge → IDLE with beep_en=0, busy=0, done=0.
- A start coincident with abort is ignored.
- A start while busy is ignored, with no restart.
- Inputs changing during playback do not affect the current message, except code_len/code_bits, which are only sampled in FETCH.
- Arithmetic: the unit counter is wide enough for UNIT_CYCLES. The symbol counter is 3 bits. The character counter is 4 bits and is compared against the clamped count.

Test Plan:
- UNIT_CYCLES=4, speed 0, count=1, "E" (len1, bits 00000): start → beep_en high exactly 4 cycles from edge k+2, then done pulse on the next cycle, busy low after.
- "A" (len2, bits 00001): beep pattern high 4, low 4, high 12 → done.
- Two chars "E","T" (len1 bits0; len1 bits1): high 4, low 12 (CGAP), high 12 → done. char_idx reads 0 then 1.
- UNIT_CYCLES=8, speed_sel=01, "E": high 4 cycles. speed_sel=11: high 2 cycles, identical to 10.
- Space between chars ("E", len0, "E"): high 4, low 12, low 16, high 4 → done. count=0 → done 1 cycle after start, beep_en never high.
- Abort at cycle 6 of a dash → beep_en=0, busy=0 next edge, no done. Also: rst driven low mid-tone asynchronously → outputs 0 without a clock edge. Start while busy → ignored.
